// File: rtl/i2c_slave_rx_if.sv
// ---------------------------------------------------------------------------
// i2c_slave_rx_if
// Bundles the pad-side and fabric-side signals of the I2C write target.
//   scl_in, sda_in : raw pin levels from the open-drain pad
//   sda_oe         : 1 = pad pulls SDA low, 0 = release
//   rx_data        : last accepted data byte
//   rx_valid       : one-clk strobe per accepted data byte
//   rx_start       : one-clk strobe when our address with W is ACKed
//   rx_stop        : one-clk strobe on STOP ending an addressed transaction
//   busy           : addressed transaction in progress
//   byte_cnt       : data bytes accepted in the current transaction
//   gencall        : general-call transaction flag (only with I2C_SLAVE_GENCALL_EN)
// Modports: slave (the target), master (pad/fabric side driving the target).
// ---------------------------------------------------------------------------
interface i2c_slave_rx_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_start;
    logic       rx_stop;
    logic       busy;
    logic [7:0] byte_cnt;
`ifdef I2C_SLAVE_GENCALL_EN
    logic       gencall;
`endif

    modport slave (
`ifdef I2C_SLAVE_GENCALL_EN
        output gencall,
`endif
        input  scl_in,
        input  sda_in,
        output sda_oe,
        output rx_data,
        output rx_valid,
        output rx_start,
        output rx_stop,
        output busy,
        output byte_cnt
    );

    modport master (
`ifdef I2C_SLAVE_GENCALL_EN
        input  gencall,
`endif
        output scl_in,
        output sda_in,
        input  sda_oe,
        input  rx_data,
        input  rx_valid,
        input  rx_start,
        input  rx_stop,
        input  busy,
        input  byte_cnt
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// i2c_slave_rx
// I2C target for write transfers. Oversamples SCL/SDA on clk, detects
// START/STOP, matches a 7-bit address, ACKs by pulling SDA low and strobes
// each accepted data byte to the fabric.
//
// Ports:
//   clk    : system clock, at least 8x the SCL frequency
//   rst_n  : asynchronous active-low reset
//   bus    : i2c_slave_rx_if.slave (pins in, sda_oe and fabric outputs out)
//
// Parameters:
//   SLAVE_ADDR : 7-bit address answered to
//   MAX_BYTES  : data bytes ACKed per transaction; later bytes are NACKed
//
// Optional build macro I2C_SLAVE_GENCALL_EN: the general-call address byte
// 8'h00 is ACKed as a match and bus.gencall flags that transaction.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | bus free or not ours, waiting for START
// S_ADDR     | shifting in the address byte
// S_ADDR_ACK | driving the address ACK slot
// S_DATA     | shifting in a data byte
// S_DATA_ACK | driving the data ACK (or NACK) slot
// S_IGNORE   | not addressed; only START/STOP are honoured
// ---------------------------------------------------------------------------
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         MAX_BYTES  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    i2c_slave_rx_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_BYTES);

    state_t     r_state, w_state_nxt;
    logic       r_scl_s1, r_scl_s2, r_scl_h;
    logic       r_sda_s1, r_sda_s2, r_sda_h;
    // Counts 0..8; the value 8 marks a complete byte awaiting its ACK slot.
    logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic       r_rx_start, w_rx_start_nxt;
    logic       r_rx_stop, w_rx_stop_nxt;
    logic       r_busy, w_busy_nxt;
    logic [7:0] r_byte_cnt, w_byte_cnt_nxt;
    logic       r_gencall, w_gencall_nxt;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic       w_addr_match, w_gc_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_h  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_h  <= 1'b1;
        end else begin
            r_scl_s1 <= bus.scl_in;
            r_scl_s2 <= r_scl_s1;
            r_scl_h  <= r_scl_s2;
            r_sda_s1 <= bus.sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_h  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_h;
    assign w_scl_fall = ~r_scl_s2 & r_scl_h;
    assign w_start    = r_sda_h & ~r_sda_s2 & r_scl_s2;
    assign w_stop     = ~r_sda_h & r_sda_s2 & r_scl_s2;

`ifdef I2C_SLAVE_GENCALL_EN
    assign w_gc_match   = (r_shift == 8'h00);
    assign w_addr_match = (r_shift == {SLAVE_ADDR, 1'b0}) | w_gc_match;
`else
    assign w_gc_match   = 1'b0;
    assign w_addr_match = (r_shift == {SLAVE_ADDR, 1'b0});
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'd0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_start <= 1'b0;
            r_rx_stop  <= 1'b0;
            r_busy     <= 1'b0;
            r_byte_cnt <= 8'd0;
            r_gencall  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_rx_start <= w_rx_start_nxt;
            r_rx_stop  <= w_rx_stop_nxt;
            r_busy     <= w_busy_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_gencall  <= w_gencall_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_sda_oe_nxt   = r_sda_oe;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_rx_start_nxt = 1'b0;
        w_rx_stop_nxt  = 1'b0;
        w_busy_nxt     = r_busy;
        w_byte_cnt_nxt = r_byte_cnt;
        w_gencall_nxt  = r_gencall;

        // Bus conditions override any bit activity in the same clk.
        if (w_stop) begin
            w_state_nxt   = S_IDLE;
            w_sda_oe_nxt  = 1'b0;
            w_gencall_nxt = 1'b0;
            if (r_busy) begin
                w_rx_stop_nxt = 1'b1;
                w_busy_nxt    = 1'b0;
            end
        end else if (w_start) begin
            // busy is kept across a repeated START until the new address decides.
            w_state_nxt    = S_ADDR;
            w_sda_oe_nxt   = 1'b0;
            w_bit_cnt_nxt  = 4'd0;
            w_byte_cnt_nxt = 8'd0;
            w_gencall_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                end
                S_ADDR: begin
                    if (w_scl_rise && r_bit_cnt != 4'd8) begin
                        w_shift_nxt   = {r_shift[6:0], r_sda_s2};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        if (w_addr_match) begin
                            w_sda_oe_nxt   = 1'b1;
                            w_busy_nxt     = 1'b1;
                            w_rx_start_nxt = 1'b1;
                            w_gencall_nxt  = w_gc_match;
                            w_state_nxt    = S_ADDR_ACK;
                        end else begin
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt  = 1'b0;
                        w_bit_cnt_nxt = 4'd0;
                        w_state_nxt   = S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_scl_rise && r_bit_cnt != 4'd8) begin
                        w_shift_nxt   = {r_shift[6:0], r_sda_s2};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        if (r_byte_cnt < MAX_CNT) begin
                            w_rx_data_nxt  = r_shift;
                            w_rx_valid_nxt = 1'b1;
                            w_byte_cnt_nxt = r_byte_cnt + 8'd1;
                            w_sda_oe_nxt   = 1'b1;
                        end else begin
                            w_sda_oe_nxt   = 1'b0;
                        end
                        w_state_nxt = S_DATA_ACK;
                    end
                end
                S_DATA_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt  = 1'b0;
                        w_bit_cnt_nxt = 4'd0;
                        w_state_nxt   = S_DATA;
                    end
                end
                S_IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe   = r_sda_oe;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_start = r_rx_start;
    assign bus.rx_stop  = r_rx_stop;
    assign bus.busy     = r_busy;
    assign bus.byte_cnt = r_byte_cnt;
`ifdef I2C_SLAVE_GENCALL_EN
    assign bus.gencall  = r_gencall;
`else
    logic w_unused_gencall;
    assign w_unused_gencall = r_gencall;
`endif

endmodule

// File: tb/tb_i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_rx
// Bench for i2c_slave_rx: an I2C write master drives SCL/SDA through a
// wired-AND pin model; a monitor pops expected data bytes from a queue on
// every rx_valid strobe and tallies rx_start/rx_stop/sda_oe/busy activity.
// Honours I2C_SLAVE_GENCALL_EN for the general-call case.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_slave_rx;
    localparam int Q = 5;   // quarter SCL period in clk cycles
`ifdef I2C_SLAVE_GENCALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic r_scl = 1'b1;
    logic r_sda = 1'b1;

    always #5 clk = ~clk;

    i2c_slave_rx_if bus ();

    assign bus.scl_in = r_scl;
    assign bus.sda_in = r_sda & ~bus.sda_oe;

    i2c_slave_rx #(.SLAVE_ADDR(7'h50), .MAX_BYTES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    int cnt_start = 0, cnt_stop = 0, cnt_oe = 0, cnt_busy_hi = 0, cnt_busy_fall = 0;
    int s_start, s_stop, s_oe, s_busy_hi, s_busy_fall;

    // Scoreboard monitor
    initial begin
        logic prev_busy;
        logic [7:0] e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.rx_valid) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rx_valid_unexpected: got data %02h, expected no strobe", bus.rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.rx_data !== e) begin
                            n_err++;
                            $display("FAIL rx_data: got %02h expected %02h", bus.rx_data, e);
                        end
                    end
                end
                if (bus.rx_start) cnt_start++;
                if (bus.rx_stop) cnt_stop++;
                if (bus.sda_oe) cnt_oe++;
                if (bus.busy) cnt_busy_hi++;
                if (prev_busy && !bus.busy) cnt_busy_fall++;
                prev_busy = bus.busy;
            end else begin
                prev_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_start = cnt_start; s_stop = cnt_stop; s_oe = cnt_oe;
        s_busy_hi = cnt_busy_hi; s_busy_fall = cnt_busy_fall;
    endtask

    task automatic i2c_start();
        r_sda = 1'b1; wq(Q);
        r_scl = 1'b1; wq(Q);
        r_sda = 1'b0; wq(Q);
        r_scl = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop();
        r_sda = 1'b0; wq(Q);
        r_scl = 1'b1; wq(Q);
        r_sda = 1'b1; wq(2*Q);
    endtask

    task automatic bit_out(input logic b, output logic pin);
        r_sda = b;    wq(Q);
        r_scl = 1'b1; wq(Q);
        pin = bus.sda_in;
        wq(Q);
        r_scl = 1'b0; wq(Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic pin;
        for (int i = 7; i >= 0; i--) bit_out(b[i], pin);
        bit_out(1'b1, pin);
        ack = ~pin;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sda_oe"},   bus.sda_oe,   0);
        chk({tag, "_rx_data"},  bus.rx_data,  0);
        chk({tag, "_rx_valid"}, bus.rx_valid, 0);
        chk({tag, "_rx_start"}, bus.rx_start, 0);
        chk({tag, "_rx_stop"},  bus.rx_stop,  0);
        chk({tag, "_busy"},     bus.busy,     0);
        chk({tag, "_byte_cnt"}, bus.byte_cnt, 0);
    endtask

    initial begin
        logic ack, pin;
        wq(5);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        wq(5);

        // Two-byte write to our address
        snap();
        i2c_start();
        wr_byte(8'hA0, ack); chk("t1_addr_ack", ack, 1);
        exp_q.push_back(8'h12);
        wr_byte(8'h12, ack); chk("t1_d0_ack", ack, 1);
        exp_q.push_back(8'h34);
        wr_byte(8'h34, ack); chk("t1_d1_ack", ack, 1);
        chk("t1_busy_mid", bus.busy, 1);
        i2c_stop(); wq(4);
        chk("t1_rx_start", cnt_start - s_start, 1);
        chk("t1_rx_stop", cnt_stop - s_stop, 1);
        chk("t1_byte_cnt", bus.byte_cnt, 2);
        chk("t1_rx_data_hold", bus.rx_data, 8'h34);
        chk("t1_busy_end", bus.busy, 0);
        chk("t1_q_empty", exp_q.size(), 0);

        // Address mismatch
        snap();
        i2c_start();
        wr_byte(8'hA2, ack); chk("t2_addr_nack", ack, 0);
        wr_byte(8'hFF, ack); chk("t2_data_nack", ack, 0);
        i2c_stop(); wq(4);
        chk("t2_oe_never", cnt_oe - s_oe, 0);
        chk("t2_busy_never", cnt_busy_hi - s_busy_hi, 0);
        chk("t2_rx_start", cnt_start - s_start, 0);
        chk("t2_rx_stop", cnt_stop - s_stop, 0);

        // Read request to our address is NACKed
        snap();
        i2c_start();
        wr_byte(8'hA1, ack); chk("t3_read_nack", ack, 0);
        wr_byte(8'h5A, ack); chk("t3_ignore_nack", ack, 0);
        i2c_stop(); wq(4);
        chk("t3_rx_start", cnt_start - s_start, 0);
        chk("t3_rx_stop", cnt_stop - s_stop, 0);
        chk("t3_byte_cnt", bus.byte_cnt, 0);

        // 17 bytes: the last one exceeds MAX_BYTES
        snap();
        i2c_start();
        wr_byte(8'hA0, ack); chk("t4_addr_ack", ack, 1);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            wr_byte(8'(i), ack);
            chk($sformatf("t4_ack_%0d", i), ack, (i < 16) ? 1 : 0);
        end
        chk("t4_byte_cnt_sat", bus.byte_cnt, 16);
        i2c_stop(); wq(4);
        chk("t4_byte_cnt_hold", bus.byte_cnt, 16);
        chk("t4_rx_data_last", bus.rx_data, 8'h0F);
        chk("t4_q_empty", exp_q.size(), 0);

        // Repeated START to ourselves
        snap();
        i2c_start();
        wr_byte(8'hA0, ack); chk("t5_addr0_ack", ack, 1);
        exp_q.push_back(8'h55);
        wr_byte(8'h55, ack); chk("t5_d0_ack", ack, 1);
        i2c_start();
        wr_byte(8'hA0, ack); chk("t5_addr1_ack", ack, 1);
        chk("t5_byte_cnt_rs", bus.byte_cnt, 0);
        chk("t5_busy_rs", bus.busy, 1);
        exp_q.push_back(8'hAA);
        wr_byte(8'hAA, ack); chk("t5_d1_ack", ack, 1);
        i2c_stop(); wq(4);
        chk("t5_byte_cnt", bus.byte_cnt, 1);
        chk("t5_rx_start", cnt_start - s_start, 2);
        chk("t5_busy_falls", cnt_busy_fall - s_busy_fall, 1);
        chk("t5_rx_stop", cnt_stop - s_stop, 1);
        chk("t5_q_empty", exp_q.size(), 0);

        // General call address
        snap();
        i2c_start();
        wr_byte(8'h00, ack); chk("t6_gc_ack", ack, GC_EN);
`ifdef I2C_SLAVE_GENCALL_EN
        chk("t6_gencall_flag", bus.gencall, 1);
`endif
        if (GC_EN) exp_q.push_back(8'h77);
        wr_byte(8'h77, ack); chk("t6_d0_ack", ack, GC_EN);
        i2c_stop(); wq(4);
        chk("t6_rx_stop", cnt_stop - s_stop, GC_EN ? 1 : 0);
        chk("t6_q_empty", exp_q.size(), 0);

        // Reset during the address ACK slot
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_out(8'hA0 >> i, pin);
        chk("t7_oe_in_ack", bus.sda_oe, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t7_oe_async", bus.sda_oe, 0);
        r_scl = 1'b1; r_sda = 1'b1;
        wq(3);
        rst_n = 1'b1;
        wq(3);
        chk_reset_outputs("t7_post");

        // Normal operation after reset
        snap();
        i2c_start();
        wr_byte(8'hA0, ack); chk("t8_addr_ack", ack, 1);
        exp_q.push_back(8'h9C);
        wr_byte(8'h9C, ack); chk("t8_d0_ack", ack, 1);
        i2c_stop(); wq(4);
        chk("t8_byte_cnt", bus.byte_cnt, 1);
        chk("t8_rx_start", cnt_start - s_start, 1);
        chk("t8_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
